// File: rtl/nodf_status_pkg.sv
// Shared types for the non-dataflow module status tracker: tracker states and
// proto_err bit positions.
package nodf_status_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } state_t;

  localparam int PERR_DONE_IDLE  = 0;  // ap_done in IDLE without ap_start
  localparam int PERR_START_DROP = 1;  // ap_start dropped before any ap_ready
  localparam int PERR_CONT_IDLE  = 2;  // ap_continue withheld with nothing pending

endpackage

// File: rtl/nodf_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module nodf_sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (inc && (q_q != '1)) begin
      q_q <= q_q + W'(1);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/nodf_module_status_tracker.sv
// Activity/latency tracker for one ap_start/ap_ready/ap_done/ap_continue block.
// Optional protocol checker enabled with macro NODF_PROTO_CHECK_EN.
module nodf_module_status_tracker
  import nodf_status_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int LAT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic             frozen,
  output logic [CNT_W-1:0] start_count,
  output logic [CNT_W-1:0] ready_count,
  output logic [CNT_W-1:0] done_count,
  output logic [CNT_W-1:0] busy_cycles,
  output logic [CNT_W-1:0] idle_cycles,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [LAT_W-1:0] last_latency,
  output logic [LAT_W-1:0] max_latency,
  output logic [2:0]       proto_err
);

  state_t           state_q, state_d;
  logic             frozen_q;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d, lat_inc;
  logic [LAT_W-1:0] last_q, last_d, max_q, max_d, latency;
  logic             start_inc, ready_inc, done_inc, busy_inc, idle_inc, stall_inc;

  assign lat_inc = (lat_cnt_q == '1) ? lat_cnt_q : lat_cnt_q + LAT_W'(1);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    last_d    = last_q;
    max_d     = max_q;
    latency   = '0;
    start_inc = 1'b0;
    ready_inc = 1'b0;
    done_inc  = 1'b0;
    busy_inc  = 1'b0;
    idle_inc  = 1'b0;
    stall_inc = 1'b0;
    if (!frozen_q) begin
      unique case (state_q)
        IDLE: begin
          if (ap_start) begin
            start_inc = 1'b1;
            busy_inc  = 1'b1;
            ready_inc = ap_ready;
            lat_cnt_d = LAT_W'(1);
            if (ap_done) begin
              done_inc = 1'b1;
              latency  = LAT_W'(1);
              state_d  = ap_continue ? IDLE : DONE_WAIT;
            end else begin
              state_d = BUSY;
            end
          end else begin
            idle_inc = 1'b1;
          end
        end
        BUSY: begin
          busy_inc  = 1'b1;
          ready_inc = ap_ready;
          lat_cnt_d = lat_inc;
          if (ap_done) begin
            done_inc = 1'b1;
            latency  = lat_inc;
            if (!ap_continue) begin
              state_d = DONE_WAIT;
            end else if (ap_start) begin
              // Back-to-back: the done cycle is also the next accept cycle.
              state_d   = BUSY;
              start_inc = 1'b1;
              lat_cnt_d = LAT_W'(1);
            end else begin
              state_d = IDLE;
            end
          end
        end
        DONE_WAIT: begin
          stall_inc = 1'b1;
          if (ap_continue) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (done_inc) begin
        last_d = latency;
        if (latency > max_q) max_d = latency;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      frozen_q  <= 1'b0;
      lat_cnt_q <= '0;
      last_q    <= '0;
      max_q     <= '0;
    end else begin
      state_q   <= state_d;
      frozen_q  <= frozen_q | finish;
      lat_cnt_q <= lat_cnt_d;
      last_q    <= last_d;
      max_q     <= max_d;
    end
  end

  nodf_sat_counter #(.W(CNT_W)) u_start_cnt (.clock(clock), .reset(reset), .clr(1'b0), .inc(start_inc), .q(start_count));
  nodf_sat_counter #(.W(CNT_W)) u_ready_cnt (.clock(clock), .reset(reset), .clr(1'b0), .inc(ready_inc), .q(ready_count));
  nodf_sat_counter #(.W(CNT_W)) u_done_cnt  (.clock(clock), .reset(reset), .clr(1'b0), .inc(done_inc),  .q(done_count));
  nodf_sat_counter #(.W(CNT_W)) u_busy_cnt  (.clock(clock), .reset(reset), .clr(1'b0), .inc(busy_inc),  .q(busy_cycles));
  nodf_sat_counter #(.W(CNT_W)) u_idle_cnt  (.clock(clock), .reset(reset), .clr(1'b0), .inc(idle_inc),  .q(idle_cycles));
  nodf_sat_counter #(.W(CNT_W)) u_stall_cnt (.clock(clock), .reset(reset), .clr(1'b0), .inc(stall_inc), .q(stall_cycles));

  assign state        = state_q;
  assign frozen       = frozen_q;
  assign last_latency = last_q;
  assign max_latency  = max_q;

`ifdef NODF_PROTO_CHECK_EN
  logic [2:0] perr_q, perr_d;
  logic       seen_ready_q, seen_ready_d;

  always_comb begin
    perr_d       = perr_q;
    seen_ready_d = seen_ready_q;
    if (!frozen_q) begin
      if (state_q == IDLE && ap_done && !ap_start)
        perr_d[PERR_DONE_IDLE] = 1'b1;
      if (state_q == BUSY && !ap_start && !ap_ready && !seen_ready_q)
        perr_d[PERR_START_DROP] = 1'b1;
      if (state_q == IDLE && !ap_continue && !ap_done)
        perr_d[PERR_CONT_IDLE] = 1'b1;
      if (start_inc)
        seen_ready_d = ap_ready;
      else if (state_q == BUSY)
        seen_ready_d = seen_ready_q | ap_ready;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perr_q       <= '0;
      seen_ready_q <= 1'b0;
    end else begin
      perr_q       <= perr_d;
      seen_ready_q <= seen_ready_d;
    end
  end

  assign proto_err = perr_q;
`else
  assign proto_err = 3'b000;
`endif

endmodule

// File: tb/tb_nodf_module_status_tracker.sv
// Self-checking bench for nodf_module_status_tracker: directed scenarios plus
// randomized handshakes against a transaction-level reference model.
module tb_nodf_module_status_tracker;

  localparam int CNT_W = 8;
  localparam int LAT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int LMAX  = (1 << LAT_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0;
  logic             ap_continue = 1'b1, finish = 1'b0;
  logic [1:0]       state;
  logic             frozen;
  logic [CNT_W-1:0] start_count, ready_count, done_count;
  logic [CNT_W-1:0] busy_cycles, idle_cycles, stall_cycles;
  logic [LAT_W-1:0] last_latency, max_latency;
  logic [2:0]       proto_err;

  int total = 0;
  int bad   = 0;

  nodf_module_status_tracker #(.CNT_W(CNT_W), .LAT_W(LAT_W)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .state(state), .frozen(frozen), .start_count(start_count),
    .ready_count(ready_count), .done_count(done_count),
    .busy_cycles(busy_cycles), .idle_cycles(idle_cycles),
    .stall_cycles(stall_cycles), .last_latency(last_latency),
    .max_latency(max_latency), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  // Reference model: "where the monitored transaction is" plus event tallies.
  int  m_where;            // 0 no transaction, 1 in flight, 2 result waiting
  bit  m_frozen;
  int  m_start, m_ready, m_done, m_busy, m_idle, m_stall;
  int  m_age, m_last, m_max;
  bit  m_seen_ready;
  bit [2:0] m_perr;

  function automatic int bump(input int v, input int lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  task automatic model_reset();
    m_where = 0; m_frozen = 0;
    m_start = 0; m_ready = 0; m_done = 0; m_busy = 0; m_idle = 0; m_stall = 0;
    m_age = 0; m_last = 0; m_max = 0; m_seen_ready = 0; m_perr = 0;
  endtask

  task automatic finish_txn(input int lat);
    m_done = bump(m_done, CMAX);
    m_last = lat;
    if (lat > m_max) m_max = lat;
  endtask

  task automatic accept(input bit r);
    m_start = bump(m_start, CMAX);
    m_age = 1;
    m_seen_ready = r;
  endtask

  task automatic model_step(input bit s, input bit r, input bit d, input bit c, input bit f);
    if (m_frozen) return;
`ifdef NODF_PROTO_CHECK_EN
    if (m_where == 0 && d && !s) m_perr[0] = 1;
    if (m_where == 1 && !s && !r && !m_seen_ready) m_perr[1] = 1;
    if (m_where == 0 && !c && !d) m_perr[2] = 1;
`endif
    if (m_where == 0 && !s) begin
      m_idle = bump(m_idle, CMAX);
    end else if (m_where == 0) begin
      accept(r);
      m_busy = bump(m_busy, CMAX);
      if (r) m_ready = bump(m_ready, CMAX);
      if (d) begin
        finish_txn(1);
        m_where = c ? 0 : 2;
      end else begin
        m_where = 1;
      end
    end else if (m_where == 1) begin
      m_busy = bump(m_busy, CMAX);
      if (r) m_ready = bump(m_ready, CMAX);
      m_seen_ready = m_seen_ready | r;
      m_age = bump(m_age, LMAX);
      if (d) begin
        finish_txn(m_age);
        if (!c) m_where = 2;
        else if (s) accept(r);
        else m_where = 0;
      end
    end else begin
      m_stall = bump(m_stall, CMAX);
      if (c) m_where = 0;
    end
    if (f) m_frozen = 1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},  64'(state),        64'(m_where));
    chk({tag, ".frozen"}, 64'(frozen),       64'(m_frozen));
    chk({tag, ".start"},  64'(start_count),  64'(m_start));
    chk({tag, ".ready"},  64'(ready_count),  64'(m_ready));
    chk({tag, ".done"},   64'(done_count),   64'(m_done));
    chk({tag, ".busy"},   64'(busy_cycles),  64'(m_busy));
    chk({tag, ".idle"},   64'(idle_cycles),  64'(m_idle));
    chk({tag, ".stall"},  64'(stall_cycles), 64'(m_stall));
    chk({tag, ".last"},   64'(last_latency), 64'(m_last));
    chk({tag, ".max"},    64'(max_latency),  64'(m_max));
    chk({tag, ".perr"},   64'(proto_err),    64'(m_perr));
  endtask

  // Inputs are applied between edges; outputs are sampled 1 time unit after the edge.
  task automatic step(input bit s, input bit r, input bit d, input bit c, input bit f);
    ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
    @(posedge clock);
    model_step(s, r, d, c, f);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0;
    #2;
    model_reset();
    check_all(tag);
    reset = 1'b1;
  endtask

  initial begin
    @(posedge clock);
    #1;

    // Reset then idle
    do_reset("rst0");
    repeat (5) step(0, 0, 0, 1, 0);
    check_all("idle5");
    chk("idle5.const", 64'(idle_cycles), 64'd5);

    // Single transaction, latency 4
    do_reset("rst1");
    step(1, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    check_all("txn");
    chk("txn.lat4",  64'(last_latency), 64'd4);
    chk("txn.max4",  64'(max_latency),  64'd4);
    chk("txn.busy4", 64'(busy_cycles),  64'd4);

    // Continue withheld for three cycles
    do_reset("rst2");
    step(1, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    chk("dw.s1", 64'(state), 64'd2);
    step(0, 0, 0, 0, 0);
    chk("dw.s2", 64'(state), 64'd2);
    step(1, 0, 0, 0, 0);
    chk("dw.s3", 64'(state), 64'd2);
    step(0, 0, 0, 1, 0);
    check_all("dw");
    chk("dw.stall3", 64'(stall_cycles), 64'd3);
    chk("dw.idle",   64'(state),        64'd0);

    // Back-to-back: latencies 3 then 2
    do_reset("rst3");
    step(1, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 1, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    check_all("b2b");
    chk("b2b.start", 64'(start_count),  64'd2);
    chk("b2b.done",  64'(done_count),   64'd2);
    chk("b2b.last",  64'(last_latency), 64'd2);
    chk("b2b.max",   64'(max_latency),  64'd3);

    // finish in BUSY freezes everything
    do_reset("rst4");
    step(1, 1, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    chk("fz.frozen", 64'(frozen),      64'd1);
    chk("fz.busy",   64'(busy_cycles), 64'd2);
    for (int i = 0; i < 10; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    check_all("fz.hold");
    chk("fz.busy_hold", 64'(busy_cycles), 64'd2);
    do_reset("fz.rst");
    chk("fz.unfrozen", 64'(frozen), 64'd0);

    // Counter and latency saturation
    do_reset("rst5");
    repeat (300) step(0, 0, 0, 1, 0);
    chk("sat.idle", 64'(idle_cycles), 64'(CMAX));
    step(1, 1, 0, 1, 0);
    repeat (20) step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    check_all("sat");
    chk("sat.lat", 64'(last_latency), 64'(LMAX));

    // Stray ap_done in IDLE is not a completion
    do_reset("rst6");
    step(0, 0, 1, 1, 0);
    check_all("stray");
    chk("stray.done", 64'(done_count), 64'd0);
    step(0, 0, 0, 1, 0);
`ifdef NODF_PROTO_CHECK_EN
    chk("stray.perr", 64'(proto_err), 64'd1);
`else
    chk("stray.perr", 64'(proto_err), 64'd0);
`endif

    // Randomized handshakes, finish raised near the end
    do_reset("rst7");
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(99) < 40, $urandom_range(99) < 50, $urandom_range(99) < 30,
           $urandom_range(99) < 80, i == 1400);
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
